// File: rtl/cache_mem_arb_pkg.sv
// cache_mem_arb_pkg: shared sizes (`NumCaches, `maxTrans), cache index constants and arbiter state encoding
`ifndef NumCaches
`define NumCaches 3
`endif
`ifndef maxTrans
`define maxTrans 16
`endif
package cache_mem_arb_pkg;
  localparam int NUMCACHES = `NumCaches;
  localparam int MAXTRANS = `maxTrans;
  localparam int IC_IDX = 0;
  localparam int T0C_IDX = 1;
  localparam int LC_IDX = 2;
  typedef enum logic [1:0] {IDLE, ISSUE, STREAM, DONE} memarb_state_t;
endpackage

// File: rtl/cache_mem_arb_rr_pick.sv
// rr_pick: combinational round-robin select; in req vector + pointer, out one-hot grant, grant index, any
module rr_pick #(
  parameter int N = 3,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx,
  output logic          any
);
  always_comb begin
    int j;
    j = 0;
    grant = '0;
    idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      j = int'(ptr) + i;
      j = (j >= N) ? j - N : j;
      if (req[j]) begin
        grant = '0;
        grant[j] = 1'b1;
        idx = IW'(j);
      end
    end
  end
  assign any = |req;
endmodule

// File: rtl/cache_mem_arb.sv
// cache_mem_arb: round-robin cache-miss arbiter onto one SDRAM burst read port; in clk/rst, per-cache readReq/addr_cache_to_sdram/transSize, mem_rd_ack/valid/data; out per-cache readValid_out/readData/doneRead, mem_rd_req/addr/len; CACHE_MEM_ARB_PERF_EN adds perf_grants/perf_wait
module cache_mem_arb
  import cache_mem_arb_pkg::*;
#(
  parameter int NUM_CACHES = NUMCACHES,
  parameter int MAX_TRANS = MAXTRANS,
  parameter int ADDR_W = 25,
  localparam int TS_W = $clog2(MAX_TRANS),
  localparam int IW = (NUM_CACHES > 1) ? $clog2(NUM_CACHES) : 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_CACHES*ADDR_W-1:0] addr_cache_to_sdram,
  input  logic [NUM_CACHES*TS_W-1:0]   transSize,
  input  logic [NUM_CACHES-1:0]        readReq,
  output logic [NUM_CACHES-1:0]        readValid_out,
  output logic [NUM_CACHES*32-1:0]     readData,
  output logic [NUM_CACHES-1:0]        doneRead,
  output logic                         mem_rd_req,
  output logic [ADDR_W-1:0]            mem_addr,
  output logic [TS_W-1:0]              mem_len,
  input  logic                         mem_rd_ack,
  input  logic                         mem_rd_valid,
  input  logic [31:0]                  mem_rd_data
`ifdef CACHE_MEM_ARB_PERF_EN
  ,
  output logic [NUM_CACHES*16-1:0]     perf_grants,
  output logic [NUM_CACHES*16-1:0]     perf_wait
`endif
);
  memarb_state_t state_q, state_d;
  logic [IW-1:0] grant_q, grant_d, ptr_q, ptr_d, pick_idx;
  logic [NUM_CACHES-1:0] goh_q, goh_d, pick_oh;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [TS_W-1:0] len_q, len_d;
  logic [TS_W:0] cnt_q, cnt_d;
  logic any_req;
  rr_pick #(.N(NUM_CACHES), .IW(IW)) u_pick (
    .req(readReq),
    .ptr(ptr_q),
    .grant(pick_oh),
    .idx(pick_idx),
    .any(any_req)
  );
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    goh_d = goh_q;
    ptr_d = ptr_q;
    addr_d = addr_q;
    len_d = len_q;
    cnt_d = cnt_q;
    case (state_q)
      IDLE: if (any_req) begin
        grant_d = pick_idx;
        goh_d = pick_oh;
        addr_d = addr_cache_to_sdram[pick_idx*ADDR_W +: ADDR_W];
        len_d = transSize[pick_idx*TS_W +: TS_W];
        state_d = (len_d == '0) ? DONE : ISSUE;
      end
      ISSUE: if (mem_rd_ack) begin
        state_d = STREAM;
        cnt_d = '0;
      end
      STREAM: if (mem_rd_valid) begin
        cnt_d = cnt_q + 1'b1;
        state_d = (cnt_d == {1'b0, len_q}) ? DONE : STREAM;
      end
      DONE: begin
        ptr_d = (int'(grant_q) == NUM_CACHES - 1) ? '0 : grant_q + 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      grant_q <= '0;
      goh_q <= '0;
      ptr_q <= '0;
      addr_q <= '0;
      len_q <= '0;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      goh_q <= goh_d;
      ptr_q <= ptr_d;
      addr_q <= addr_d;
      len_q <= len_d;
      cnt_q <= cnt_d;
    end
  end
  assign mem_rd_req = state_q == ISSUE;
  assign mem_addr = addr_q;
  assign mem_len = len_q;
  assign readValid_out = (state_q == STREAM && mem_rd_valid) ? goh_q : '0;
  assign doneRead = (state_q == DONE) ? goh_q : '0;
  assign readData = {NUM_CACHES{mem_rd_data}};
`ifdef CACHE_MEM_ARB_PERF_EN
  logic [NUM_CACHES-1:0][15:0] pg_q, pg_d, pw_q, pw_d;
  always_comb begin
    pg_d = pg_q;
    pw_d = pw_q;
    for (int i = 0; i < NUM_CACHES; i++) begin
      pg_d[i] = pg_q[i] + {15'd0, state_q == DONE && goh_q[i] && pg_q[i] != 16'hFFFF};
      pw_d[i] = pw_q[i] + {15'd0, readReq[i] && !(state_q != IDLE && goh_q[i]) && pw_q[i] != 16'hFFFF};
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      pg_q <= '0;
      pw_q <= '0;
    end else begin
      pg_q <= pg_d;
      pw_q <= pw_d;
    end
  end
  assign perf_grants = pg_q;
  assign perf_wait = pw_q;
`endif
endmodule

// File: tb/tb_cache_mem_arb.sv
// tb_cache_mem_arb: randomized self-checking bench for cache_mem_arb against a round-robin transaction model
module tb_cache_mem_arb;
  import cache_mem_arb_pkg::*;
  localparam int NC = NUMCACHES;
  localparam int TS_W = $clog2(MAXTRANS);
  logic clk = 1'b0;
  logic rst;
  logic [NC-1:0] readReq, readValid_out, doneRead;
  logic [24:0] addr_a [NC];
  logic [TS_W-1:0] ts_a [NC];
  logic [NC*25-1:0] addr_flat;
  logic [NC*TS_W-1:0] ts_flat;
  logic [NC*32-1:0] readData;
  logic mem_rd_req, mem_rd_ack, mem_rd_valid;
  logic [24:0] mem_addr;
  logic [TS_W-1:0] mem_len;
  logic [31:0] mem_rd_data;
`ifdef CACHE_MEM_ARB_PERF_EN
  logic [NC*16-1:0] perf_grants, perf_wait;
`endif
  int tests = 0;
  int fails = 0;
  int ptr = 0;
  logic [NC-1:0] req_v;
  always #5 clk = ~clk;
  for (genvar g = 0; g < NC; g++) begin : g_flat
    assign addr_flat[g*25 +: 25] = addr_a[g];
    assign ts_flat[g*TS_W +: TS_W] = ts_a[g];
  end
  cache_mem_arb dut (
    .clk(clk),
    .rst(rst),
    .addr_cache_to_sdram(addr_flat),
    .transSize(ts_flat),
    .readReq(readReq),
    .readValid_out(readValid_out),
    .readData(readData),
    .doneRead(doneRead),
    .mem_rd_req(mem_rd_req),
    .mem_addr(mem_addr),
    .mem_len(mem_len),
    .mem_rd_ack(mem_rd_ack),
    .mem_rd_valid(mem_rd_valid),
    .mem_rd_data(mem_rd_data)
`ifdef CACHE_MEM_ARB_PERF_EN
    ,
    .perf_grants(perf_grants),
    .perf_wait(perf_wait)
`endif
  );
  function automatic int pick(input logic [NC-1:0] r, input int p);
    for (int k = 0; k < NC; k++) if (r[(p + k) % NC]) return (p + k) % NC;
    return 0;
  endfunction
  task automatic step(input logic r, input logic [NC-1:0] rq, input logic ack, input logic vld, input logic [31:0] d);
    @(negedge clk);
    rst = r;
    readReq = rq;
    mem_rd_ack = ack;
    mem_rd_valid = vld;
    mem_rd_data = d;
    #1;
  endtask
  task automatic serve(input int ack_dly, input bit drop, output int n);
    int g, el, beats;
    logic [NC-1:0] oh;
    logic [24:0] ea;
    logic vld;
    logic [31:0] d;
    g = pick(req_v, ptr);
    oh = NC'(1) << g;
    ea = addr_a[g];
    el = int'(ts_a[g]);
    n = 0;
    do begin
      step(1'b0, req_v, 1'b0, 1'($urandom), $urandom);
      n++;
      tests++;
      if (readValid_out !== '0) begin
        fails++;
        $display("FAIL idle_strobe: readValid_out=%b want 0", readValid_out);
      end
    end while (!mem_rd_req && doneRead === '0 && n < 20);
    if (el == 0) begin
      tests++;
      if (doneRead !== oh || mem_rd_req !== 1'b0) begin
        fails++;
        $display("FAIL zero_len_done: doneRead=%b mem_rd_req=%b want %b/0", doneRead, mem_rd_req, oh);
      end
    end else begin
      tests++;
      if (mem_rd_req !== 1'b1 || mem_addr !== ea || mem_len !== TS_W'(el)) begin
        fails++;
        $display("FAIL issue: req=%b addr=%h len=%0d want 1/%h/%0d", mem_rd_req, mem_addr, mem_len, ea, el);
      end
      for (int k = 0; k <= ack_dly; k++) begin
        step(1'b0, req_v, k == ack_dly, 1'($urandom), $urandom);
        tests++;
        if (mem_rd_req !== 1'b1 || mem_addr !== ea || mem_len !== TS_W'(el) || readValid_out !== '0) begin
          fails++;
          $display("FAIL issue_hold: req=%b addr=%h len=%0d strobe=%b want 1/%h/%0d/0", mem_rd_req, mem_addr, mem_len, readValid_out, ea, el);
        end
      end
      beats = 0;
      for (int t = 0; t < 200 && beats < el; t++) begin
        vld = $urandom_range(0, 2) != 0;
        d = $urandom;
        step(1'b0, req_v, 1'b0, vld, d);
        tests++;
        if (readValid_out !== (vld ? oh : '0) || readData !== {NC{d}} || doneRead !== '0 || mem_rd_req !== 1'b0) begin
          fails++;
          $display("FAIL stream: strobe=%b data=%h done=%b req=%b want %b/%h/0/0", readValid_out, readData, doneRead, mem_rd_req, vld ? oh : '0, {NC{d}});
        end
        beats += int'(vld);
      end
      step(1'b0, req_v, 1'b0, 1'($urandom), $urandom);
      tests++;
      if (doneRead !== oh || readValid_out !== '0) begin
        fails++;
        $display("FAIL done: doneRead=%b strobe=%b want %b/0", doneRead, readValid_out, oh);
      end
    end
    ptr = (g + 1) % NC;
    if (drop) req_v = '0;
    step(1'b0, req_v, 1'b0, 1'($urandom), $urandom);
    tests++;
    if (doneRead !== '0 || readValid_out !== '0) begin
      fails++;
      $display("FAIL done_once: doneRead=%b strobe=%b want 0/0", doneRead, readValid_out);
    end
  endtask
  task automatic test_reset;
    step(1'b1, '0, 1'b0, 1'b1, $urandom);
    step(1'b1, '0, 1'b0, 1'b1, $urandom);
    tests++;
    if (mem_rd_req !== 1'b0) begin fails++; $display("FAIL reset_req: got %b want 0", mem_rd_req); end
    tests++;
    if (readValid_out !== '0) begin fails++; $display("FAIL reset_strobe: got %b want 0", readValid_out); end
    tests++;
    if (doneRead !== '0) begin fails++; $display("FAIL reset_done: got %b want 0", doneRead); end
    tests++;
    if (mem_addr !== '0) begin fails++; $display("FAIL reset_addr: got %h want 0", mem_addr); end
    tests++;
    if (mem_len !== '0) begin fails++; $display("FAIL reset_len: got %0d want 0", mem_len); end
    step(1'b0, '0, 1'b0, 1'b0, '0);
    ptr = 0;
  endtask
  task automatic test_single;
    int n;
    addr_a[T0C_IDX] = 25'h1000;
    ts_a[T0C_IDX] = 4;
    req_v = 3'b010;
    serve(0, 1'b1, n);
  endtask
  task automatic test_all_rr;
    int n;
    step(1'b1, '0, 1'b0, 1'b0, '0);
    ptr = 0;
    for (int i = 0; i < NC; i++) begin
      addr_a[i] = 25'h100 * (i + 1);
      ts_a[i] = TS_W'($urandom_range(1, 5));
    end
    req_v = 3'b111;
    step(1'b0, req_v, 1'b0, 1'b0, '0);
    for (int b = 0; b < 4; b++) begin
      tests++;
      if (pick(req_v, ptr) != b % NC) begin
        fails++;
        $display("FAIL rr_order: model=%0d want %0d", pick(req_v, ptr), b % NC);
      end
      serve($urandom_range(0, 2), 1'b0, n);
    end
    serve(0, 1'b1, n);
  endtask
  task automatic test_zero_len;
    int n;
    ts_a[LC_IDX] = 0;
    req_v = '0;
    step(1'b0, req_v, 1'b0, 1'b0, '0);
    req_v = 3'b100;
    serve(0, 1'b1, n);
    tests++;
    if (n != 2) begin fails++; $display("FAIL zero_len_latency: got %0d want 2", n); end
  endtask
  task automatic test_ack_delay;
    int n;
    addr_a[T0C_IDX] = 25'h0ABCDE;
    ts_a[T0C_IDX] = 3;
    req_v = 3'b010;
    serve(10, 1'b1, n);
  endtask
  task automatic test_rst_abort;
    int n;
    logic [31:0] d;
    for (int k = 0; k < 4; k++) begin
      step(1'b0, '0, 1'b0, 1'b1, $urandom);
      tests++;
      if (readValid_out !== '0 || doneRead !== '0) begin
        fails++;
        $display("FAIL spurious_idle: strobe=%b done=%b want 0/0", readValid_out, doneRead);
      end
    end
    addr_a[T0C_IDX] = 25'h1555;
    ts_a[T0C_IDX] = 8;
    n = 0;
    do begin
      step(1'b0, 3'b010, 1'b0, 1'b0, '0);
      n++;
    end while (!mem_rd_req && n < 20);
    tests++;
    if (mem_rd_req !== 1'b1) begin fails++; $display("FAIL abort_issue: got %b want 1", mem_rd_req); end
    step(1'b0, 3'b010, 1'b1, 1'b0, '0);
    for (int k = 0; k < 2; k++) begin
      d = $urandom;
      step(1'b0, 3'b010, 1'b0, 1'b1, d);
      tests++;
      if (readValid_out !== 3'b010) begin fails++; $display("FAIL abort_beat: got %b want 010", readValid_out); end
    end
    step(1'b1, '0, 1'b0, 1'b0, '0);
    for (int k = 0; k < 5; k++) begin
      step(k < 1, '0, 1'b0, 1'b1, $urandom);
      tests++;
      if (readValid_out !== '0 || doneRead !== '0) begin
        fails++;
        $display("FAIL abort_late: strobe=%b done=%b want 0/0", readValid_out, doneRead);
      end
      if (k == 0) begin
        tests++;
        if (mem_addr !== '0 || mem_len !== '0 || mem_rd_req !== 1'b0) begin
          fails++;
          $display("FAIL abort_reset: addr=%h len=%0d req=%b want 0/0/0", mem_addr, mem_len, mem_rd_req);
        end
      end
    end
    ptr = 0;
    for (int i = 0; i < NC; i++) ts_a[i] = TS_W'($urandom_range(1, 4));
    req_v = 3'b111;
    serve(1, 1'b1, n);
  endtask
  task automatic test_random;
    int n;
    for (int r = 0; r < 40; r++) begin
      for (int i = 0; i < NC; i++) begin
        addr_a[i] = 25'($urandom);
        ts_a[i] = TS_W'($urandom_range(0, MAXTRANS - 1));
      end
      req_v = NC'($urandom_range(1, (1 << NC) - 1));
      serve($urandom_range(0, 3), 1'b1, n);
    end
  endtask
`ifdef CACHE_MEM_ARB_PERF_EN
  task automatic test_perf;
    int n;
    step(1'b1, '0, 1'b0, 1'b0, '0);
    ptr = 0;
    for (int i = 0; i < NC; i++) ts_a[i] = 2;
    req_v = 3'b111;
    for (int b = 0; b < 6; b++) serve(0, 1'b0, n);
    for (int i = 0; i < NC; i++) begin
      tests++;
      if (perf_grants[i*16 +: 16] !== 16'd2) begin
        fails++;
        $display("FAIL perf_grants[%0d]: got %0d want 2", i, perf_grants[i*16 +: 16]);
      end
    end
    for (int i = 1; i < NC; i++) begin
      tests++;
      if (perf_wait[i*16 +: 16] === 16'd0) begin
        fails++;
        $display("FAIL perf_wait[%0d]: got 0 want nonzero", i);
      end
    end
  endtask
`endif
  initial begin
    rst = 1'b1;
    readReq = '0;
    mem_rd_ack = 1'b0;
    mem_rd_valid = 1'b0;
    mem_rd_data = '0;
    req_v = '0;
    for (int i = 0; i < NC; i++) begin
      addr_a[i] = '0;
      ts_a[i] = '0;
    end
    test_reset();
    test_single();
    test_all_rr();
    test_zero_len();
    test_ack_delay();
    test_rst_abort();
    test_random();
`ifdef CACHE_MEM_ARB_PERF_EN
    test_perf();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
